xbar_rr_param: RTL and testbench

- Parametrised N_MST x N_SLV crossbar for the shared BUS protocol (req/addr/cmd/wdata/ack/rdata); next generation of the fixed 4x4 cross_bar.
- Each slave port has its own round-robin arbiter and registered grant, so transactions to different slaves proceed concurrently.
- Sits between master ports and slave ports in the SoC top.
- Ports are flattened packed arrays; index i is the lane for master i or slave i.

---
 rtl/xbar_rr_param_if.sv | 28 ++
 rtl/xbar_rr_param.sv | 158 +++++++++++++++
 tb/tb_xbar_rr_param.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xbar_rr_param_if.sv
// Bus bundle for the xbar_rr_param crossbar: master-side lanes (m_*) and slave-side lanes (s_*).
// Lane i of each packed vector belongs to master i or slave i.
interface xbar_rr_param_if #(
  parameter int N_MST = 4,
  parameter int N_SLV = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic [N_MST-1:0]    m_req;
  logic [N_MST*AW-1:0] m_addr;
  logic [N_MST-1:0]    m_cmd;
  logic [N_MST*DW-1:0] m_wdata;
  logic [N_MST-1:0]    m_ack;
  logic [N_MST*DW-1:0] m_rdata;
  logic [N_MST-1:0]    m_err;

  logic [N_SLV-1:0]    s_req;
  logic [N_SLV*AW-1:0] s_addr;
  logic [N_SLV-1:0]    s_cmd;
  logic [N_SLV*DW-1:0] s_wdata;
  logic [N_SLV-1:0]    s_ack;
  logic [N_SLV*DW-1:0] s_rdata;

  modport master (output m_req, m_addr, m_cmd, m_wdata, input m_ack, m_rdata, m_err);
  modport slave  (input s_req, s_addr, s_cmd, s_wdata, output s_ack, s_rdata);
  modport xbar   (input m_req, m_addr, m_cmd, m_wdata, s_ack, s_rdata,
                  output m_ack, m_rdata, m_err, s_req, s_addr, s_cmd, s_wdata);
endinterface

// File: rtl/xbar_rr_param.sv
// N_MST x N_SLV crossbar with one round-robin IDLE/BUSY arbiter per slave port.
// Optional per-slave watchdog enabled by defining XBAR_TIMEOUT_EN.
module xbar_rr_param #(
  parameter int N_MST   = 4,
  parameter int N_SLV   = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  xbar_rr_param_if.xbar bus
);
  localparam int SW = $clog2(N_SLV);
  localparam int MW = $clog2(N_MST);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_r [N_SLV];
  state_t        state_s [N_SLV];
  logic [MW-1:0] gnt_r   [N_SLV];
  logic [MW-1:0] gnt_s   [N_SLV];
  logic [MW-1:0] ptr_r   [N_SLV];
  logic [MW-1:0] ptr_s   [N_SLV];
  logic [SW-1:0] dec_s   [N_MST];
  logic [N_SLV-1:0] done_s;
  logic [N_SLV-1:0] expire_s;

  // Slave index of each master taken from its top address bits
  always_comb begin
    for (int m = 0; m < N_MST; m++) begin
      dec_s[m] = bus.m_addr[m*AW + AW - 1 -: SW];
    end
  end

`ifdef XBAR_TIMEOUT_EN
  localparam int CW = 16;
  logic [CW-1:0] cnt_r [N_SLV];

  // Expiry: count reached TIMEOUT-1 and the slave is still silent (a real ack wins)
  always_comb begin
    expire_s = {N_SLV{1'b0}};
    for (int s = 0; s < N_SLV; s++) begin
      expire_s[s] = (state_r[s] == BUSY) && !bus.s_ack[s] && (cnt_r[s] == CW'(TIMEOUT - 1));
    end
  end

  // Watchdog counters: count BUSY cycles, clear whenever the slave is or goes IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < N_SLV; s++) cnt_r[s] <= {CW{1'b0}};
    end else begin
      for (int s = 0; s < N_SLV; s++) begin
        if ((state_r[s] == BUSY) && !done_s[s]) cnt_r[s] <= cnt_r[s] + CW'(1);
        else                                    cnt_r[s] <= {CW{1'b0}};
      end
    end
  end
`else
  // No watchdog in this build: TIMEOUT can never be negative, so expiry is constant 0
  assign expire_s = (TIMEOUT < 0) ? {N_SLV{1'b1}} : {N_SLV{1'b0}};
`endif

  // A BUSY slave finishes on its own ack or on watchdog expiry
  always_comb begin
    done_s = {N_SLV{1'b0}};
    for (int s = 0; s < N_SLV; s++) begin
      done_s[s] = (state_r[s] == BUSY) && (bus.s_ack[s] || expire_s[s]);
    end
  end

  // Per-slave next state: round-robin pick from rr_ptr in IDLE, release on done in BUSY
  always_comb begin
    for (int s = 0; s < N_SLV; s++) begin
      logic          found;
      logic [MW:0]   sum;
      logic [MW-1:0] idx;
      state_s[s] = state_r[s];
      gnt_s[s]   = gnt_r[s];
      ptr_s[s]   = ptr_r[s];
      found      = 1'b0;
      sum        = {(MW+1){1'b0}};
      idx        = {MW{1'b0}};
      case (state_r[s])
        IDLE: begin
          for (int k = 0; k < N_MST; k++) begin
            sum = {1'b0, ptr_r[s]} + (MW+1)'(k);
            if (sum >= (MW+1)'(N_MST)) sum = sum - (MW+1)'(N_MST);
            else                       sum = sum;
            idx = sum[MW-1:0];
            if (!found && bus.m_req[idx] && (dec_s[idx] == SW'(s))) begin
              found    = 1'b1;
              gnt_s[s] = idx;
            end else begin
              found = found;
            end
          end
          if (found) state_s[s] = BUSY;
          else       state_s[s] = IDLE;
        end
        BUSY: begin
          if (done_s[s]) begin
            state_s[s] = IDLE;
            ptr_s[s]   = (gnt_r[s] == MW'(N_MST - 1)) ? {MW{1'b0}} : gnt_r[s] + MW'(1);
          end else begin
            state_s[s] = BUSY;
          end
        end
        default: state_s[s] = IDLE;
      endcase
    end
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < N_SLV; s++) begin
        state_r[s] <= IDLE;
        gnt_r[s]   <= {MW{1'b0}};
        ptr_r[s]   <= {MW{1'b0}};
      end
    end else begin
      for (int s = 0; s < N_SLV; s++) begin
        state_r[s] <= state_s[s];
        gnt_r[s]   <= gnt_s[s];
        ptr_r[s]   <= ptr_s[s];
      end
    end
  end

  // Forward the granted master to its slave and route completion back; all zero when IDLE
  always_comb begin
    bus.s_req   = {N_SLV{1'b0}};
    bus.s_addr  = {(N_SLV*AW){1'b0}};
    bus.s_cmd   = {N_SLV{1'b0}};
    bus.s_wdata = {(N_SLV*DW){1'b0}};
    bus.m_ack   = {N_MST{1'b0}};
    bus.m_rdata = {(N_MST*DW){1'b0}};
    bus.m_err   = {N_MST{1'b0}};
    for (int s = 0; s < N_SLV; s++) begin
      if (state_r[s] == BUSY) begin
        bus.s_req[s]              = bus.m_req[gnt_r[s]];
        bus.s_addr[s*AW +: AW]    = bus.m_addr[int'(gnt_r[s])*AW +: AW];
        bus.s_cmd[s]              = bus.m_cmd[gnt_r[s]];
        bus.s_wdata[s*DW +: DW]   = bus.m_wdata[int'(gnt_r[s])*DW +: DW];
        if (done_s[s]) begin
          bus.m_ack[gnt_r[s]] = 1'b1;
          bus.m_err[gnt_r[s]] = expire_s[s];
          bus.m_rdata[int'(gnt_r[s])*DW +: DW] = bus.s_ack[s] ? bus.s_rdata[s*DW +: DW] : {DW{1'b0}};
        end else begin
          bus.m_ack[gnt_r[s]] = 1'b0;
        end
      end else begin
        bus.s_req[s] = 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_xbar_rr_param.sv
// Self-checking bench for xbar_rr_param: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level round-robin model.
module tb_xbar_rr_param;
  localparam int NM = 4;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef XBAR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   mode;          // 0: ack = s_req & mask, 1: random, 2: ack = mask
  logic [NS-1:0] dir_mask;
  logic [NM-1:0] last_ack;

  xbar_rr_param_if #(.N_MST(NM), .N_SLV(NS), .AW(AW), .DW(DW)) bus_a ();
  xbar_rr_param_if #(.N_MST(3), .N_SLV(8), .AW(32), .DW(16)) bus_b ();

  xbar_rr_param #(.N_MST(NM), .N_SLV(NS), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  xbar_rr_param #(.N_MST(3), .N_SLV(8), .AW(32), .DW(16)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_m(input int m, input logic rq, input logic [31:0] ad,
                       input logic cm, input logic [31:0] wd);
    bus_a.m_req[m]               = rq;
    bus_a.m_addr[m*AW +: AW]     = ad;
    bus_a.m_cmd[m]               = cm;
    bus_a.m_wdata[m*DW +: DW]    = wd;
  endtask

  // ---------------- reference model ----------------
  int  mbusy [NS];
  int  mgnt  [NS];
  int  mptr  [NS];
  int  mcnt  [NS];
  bit  mdone [NS];
  logic [NS-1:0]    e_sreq, e_scmd;
  logic [NS*AW-1:0] e_saddr;
  logic [NS*DW-1:0] e_swd;
  logic [NM-1:0]    e_mack, e_merr;
  logic [NM*DW-1:0] e_mrd;

  function automatic int slv_of(input int m);
    logic [31:0] a;
    a = bus_a.m_addr[m*AW +: AW];
    return int'(a[31:30]);
  endfunction

  // First requester of slave s at or after its pointer, -1 if none
  function automatic int pick(input int s);
    for (int k = 0; k < NM; k++) begin
      int m;
      m = (mptr[s] + k) % NM;
      if (bus_a.m_req[m] && slv_of(m) == s) return m;
    end
    return -1;
  endfunction

  initial begin
    last_ack = '0;
    for (int s = 0; s < NS; s++) begin
      mbusy[s] = 0; mgnt[s] = 0; mptr[s] = 0; mcnt[s] = 0;
    end
    forever begin
      @(negedge clk);
      e_sreq = '0; e_scmd = '0; e_saddr = '0; e_swd = '0;
      e_mack = '0; e_merr = '0; e_mrd = '0;
      for (int s = 0; s < NS; s++) mdone[s] = 1'b0;
      if (!reset) begin
        for (int s = 0; s < NS; s++) begin
          mbusy[s] = 0; mgnt[s] = 0; mptr[s] = 0; mcnt[s] = 0;
        end
      end else begin
        for (int s = 0; s < NS; s++) begin
          if (mbusy[s] != 0) begin
            int g;
            g = mgnt[s];
            e_sreq[s]            = bus_a.m_req[g];
            e_scmd[s]            = bus_a.m_cmd[g];
            e_saddr[s*AW +: AW]  = bus_a.m_addr[g*AW +: AW];
            e_swd[s*DW +: DW]    = bus_a.m_wdata[g*DW +: DW];
            if (bus_a.s_ack[s]) begin
              mdone[s] = 1'b1;
              e_mack[g] = 1'b1;
              e_mrd[g*DW +: DW] = bus_a.s_rdata[s*DW +: DW];
            end else if (TO_EN && mcnt[s] == TO - 1) begin
              mdone[s] = 1'b1;
              e_mack[g] = 1'b1;
              e_merr[g] = 1'b1;
            end
          end
        end
      end
      check("s_req",   128'(bus_a.s_req),   128'(e_sreq));
      check("s_addr",  128'(bus_a.s_addr),  128'(e_saddr));
      check("s_cmd",   128'(bus_a.s_cmd),   128'(e_scmd));
      check("s_wdata", 128'(bus_a.s_wdata), 128'(e_swd));
      check("m_ack",   128'(bus_a.m_ack),   128'(e_mack));
      check("m_rdata", 128'(bus_a.m_rdata), 128'(e_mrd));
      check("m_err",   128'(bus_a.m_err),   128'(e_merr));
      last_ack = e_mack;
      if (reset) begin
        for (int s = 0; s < NS; s++) begin
          if (mbusy[s] != 0) begin
            if (mdone[s]) begin
              mbusy[s] = 0; mptr[s] = (mgnt[s] + 1) % NM; mcnt[s] = 0;
            end else begin
              mcnt[s]++;
            end
          end else begin
            int w;
            w = pick(s);
            if (w >= 0) begin
              mbusy[s] = 1; mgnt[s] = w; mcnt[s] = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- slave responders ----------------
  initial begin
    bus_a.s_ack = '0;
    bus_a.s_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mode == 1) begin
        for (int s = 0; s < NS; s++) begin
          if (s == 3) bus_a.s_ack[s] = ($urandom_range(15, 0) == 0);
          else        bus_a.s_ack[s] = 1'($urandom_range(1, 0));
          bus_a.s_rdata[s*DW +: DW] = $urandom();
        end
      end else begin
        bus_a.s_ack = (mode == 2) ? dir_mask : (bus_a.s_req & dir_mask);
        for (int s = 0; s < NS; s++) bus_a.s_rdata[s*DW +: DW] = 32'hDEAD_BEEF;
      end
    end
  end

  initial begin
    bus_b.s_ack = '0;
    bus_b.s_rdata = {8{16'hA5A5}};
    forever begin
      @(posedge clk);
      #2;
      bus_b.s_ack = bus_b.s_req;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    int ord4 [5];
    int ord3 [4];
    ord4 = '{0, 1, 2, 3, 0};
    ord3 = '{0, 1, 2, 0};
    n_cmp = 0; n_err = 0; mode = 0; dir_mask = '0;
    reset = 1'b0;
    bus_a.m_req = '0; bus_a.m_addr = '0; bus_a.m_cmd = '0; bus_a.m_wdata = '0;
    bus_b.m_req = '0; bus_b.m_addr = '0; bus_b.m_cmd = '0; bus_b.m_wdata = '0;
    repeat (3) drv();
    smp();
    check("reset_s_req", 128'(bus_a.s_req), 128'(0));
    check("reset_m_ack", 128'(bus_a.m_ack), 128'(0));
    drv();
    reset = 1'b1;

    // Single read: M0 -> slave 1, acked in first BUSY cycle
    dir_mask = 4'b0010;
    drv(); set_m(0, 1'b1, 32'h4000_0010, 1'b0, 32'h0);
    smp(); check("t1_sreq_c1", 128'(bus_a.s_req), 128'(4'b0000));
    drv(); smp();
    check("t1_sreq_c2", 128'(bus_a.s_req), 128'(4'b0010));
    check("t1_mack_c2", 128'(bus_a.m_ack), 128'(4'b0001));
    check("t1_rdata", 128'(bus_a.m_rdata[0 +: DW]), 128'(32'hDEAD_BEEF));
    drv(); set_m(0, 1'b0, 32'h0, 1'b0, 32'h0);
    smp(); check("t1_mack_c3", 128'(bus_a.m_ack), 128'(4'b0000));

    // Round-robin: all four masters hold requests to slave 0
    dir_mask = 4'b0001;
    drv();
    for (int m = 0; m < NM; m++) set_m(m, 1'b1, 32'h0000_0020 + 32'(m), 1'b0, 32'h0);
    smp();
    for (int i = 1; i < 10; i++) begin
      logic [3:0] e;
      drv(); smp();
      e = (i % 2 == 1) ? 4'(1 << ord4[i/2]) : 4'b0000;
      check("t2_rr_ack", 128'(bus_a.m_ack), 128'(e));
    end
    drv(); bus_a.m_req = '0;
    smp();

    // Concurrency: M0 writes slave 2, M3 reads slave 3, same cycle
    dir_mask = 4'b0100;
    drv();
    set_m(0, 1'b1, 32'h8000_0000, 1'b1, 32'h1234_5678);
    set_m(3, 1'b1, 32'hC000_0004, 1'b0, 32'h0);
    smp(); check("t3_sreq_c1", 128'(bus_a.s_req), 128'(4'b0000));
    drv(); smp();
    check("t3_sreq_both", 128'(bus_a.s_req), 128'(4'b1100));
    check("t3_wdata2", 128'(bus_a.s_wdata[2*DW +: DW]), 128'(32'h1234_5678));
    check("t3_mack_m0", 128'(bus_a.m_ack), 128'(4'b0001));
    drv(); set_m(0, 1'b0, 32'h0, 1'b0, 32'h0); dir_mask = 4'b1100;
    smp();
    check("t3_sreq_s3", 128'(bus_a.s_req), 128'(4'b1000));
    check("t3_mack_m3", 128'(bus_a.m_ack), 128'(4'b1000));
    drv(); set_m(3, 1'b0, 32'h0, 1'b0, 32'h0); dir_mask = '0;
    smp();

`ifdef XBAR_TIMEOUT_EN
    // Timeout: slave 0 never acks
    drv(); set_m(0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    smp();
    for (int k = 1; k <= TO; k++) begin
      drv(); smp();
      if (k < TO) check("t5_no_ack", 128'(bus_a.m_ack), 128'(0));
      else begin
        check("t5_to_ack", 128'(bus_a.m_ack), 128'(4'b0001));
        check("t5_to_err", 128'(bus_a.m_err), 128'(4'b0001));
        check("t5_to_rdata", 128'(bus_a.m_rdata[0 +: DW]), 128'(0));
      end
    end
    drv(); set_m(0, 1'b0, 32'h0, 1'b0, 32'h0); mode = 2; dir_mask = 4'b0001;
    smp(); check("t5_late_ack", 128'(bus_a.m_ack), 128'(0));
    drv(); smp(); check("t5_late_ack2", 128'(bus_a.m_ack), 128'(0));
    drv(); mode = 0; dir_mask = '0;
    smp();
`endif

    // Reset mid-transaction on slave 1
    dir_mask = 4'b0010;
    drv(); set_m(2, 1'b1, 32'h4000_0000, 1'b0, 32'h0);
    smp();
    drv(); smp(); check("t4_m2_ack", 128'(bus_a.m_ack), 128'(4'b0100));
    drv(); dir_mask = '0;
    smp();
    drv(); smp(); check("t4_busy", 128'(bus_a.s_req), 128'(4'b0010));
    #2 reset = 1'b0;
    #1;
    check("t4_async_sreq", 128'(bus_a.s_req), 128'(0));
    check("t4_async_mack", 128'(bus_a.m_ack), 128'(0));
    set_m(2, 1'b0, 32'h0, 1'b0, 32'h0);
    smp();
    drv(); reset = 1'b1;
    set_m(1, 1'b1, 32'h4000_0008, 1'b0, 32'h0);
    set_m(3, 1'b1, 32'h5000_0000, 1'b1, 32'h0BAD_F00D);
    dir_mask = 4'b0010;
    smp(); check("t4_idle_after", 128'(bus_a.s_req), 128'(0));
    drv(); smp(); check("t4_first_m1", 128'(bus_a.m_ack), 128'(4'b0010));
    drv(); set_m(1, 1'b0, 32'h0, 1'b0, 32'h0);
    smp();
    drv(); smp(); check("t4_then_m3", 128'(bus_a.m_ack), 128'(4'b1000));
    drv(); set_m(3, 1'b0, 32'h0, 1'b0, 32'h0); dir_mask = '0;
    smp();

    // 3x8 build: three masters on slave 7, wrap at 3
    drv();
    bus_b.m_req  = 3'b111;
    bus_b.m_addr = {32'hE000_0008, 32'hE000_0004, 32'hE000_0000};
    smp();
    for (int i = 1; i < 8; i++) begin
      logic [2:0] e;
      drv(); smp();
      e = (i % 2 == 1) ? 3'(1 << ord3[i/2]) : 3'b000;
      check("t6_wrap_ack", 128'(bus_b.m_ack), 128'(e));
      check("t6_sreq7", 128'(bus_b.s_req), 128'((i % 2 == 1) ? 8'h80 : 8'h00));
    end
    drv(); bus_b.m_req = '0;
    smp();

    // Randomized traffic, one reset in the middle
    mode = 1;
    for (int i = 0; i < 3000; i++) begin
      drv();
      if (i == 1500) reset = 1'b0;
      else if (i == 1502) reset = 1'b1;
      for (int m = 0; m < NM; m++) begin
        if (!bus_a.m_req[m] || last_ack[m]) begin
          if ($urandom_range(2, 0) != 0)
            set_m(m, 1'b1, $urandom(), 1'($urandom_range(1, 0)), $urandom());
          else
            set_m(m, 1'b0, 32'h0, 1'b0, 32'h0);
        end
      end
    end
    drv(); bus_a.m_req = '0; mode = 0;
    repeat (3) smp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
